// File: rtl/channel_loader.sv
// channel_loader: front-end stage that saturates incoming channel LLRs,
// packs them P at a time into P*Q-bit words, and strobes each word into the
// decoder's LLR storage. After a full frame it hands the storage to the PE
// datapath until the decoder signals frame completion.
module channel_loader #(
    parameter int N     = 1024,
    parameter int P     = 64,
    parameter int Q     = 6,
    parameter int IN_W  = 8,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_llr,
    output logic               in_ready,
    output logic [P*Q-1:0]     W_channel,
    output logic [CNT_W-1:0]   channel_count,
    output logic               channel_ready,
    output logic               channel,
    input  logic               frame_done,
    output logic               busy
);

    localparam int WORDS   = N / P;
    localparam int LANE_W  = (P > 1) ? $clog2(P) : 1;
    localparam int SAT_MAX = 2 ** (Q - 1) - 1;
    localparam bit CLIP    = (IN_W > Q);

    // Reject parameter sets whose word index cannot be represented.
    if ((2 ** CNT_W) < WORDS || (N % P) != 0) begin : g_param_check
        $error("channel_loader: CNT_W too small for N/P or N not a multiple of P");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DEC
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [LANE_W-1:0]   r_lane_cnt;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [P*Q-1:0]      r_pack;
    logic [P*Q-1:0]      r_w_channel;
    logic [CNT_W-1:0]    r_channel_count;
    logic                r_channel_ready;

    logic                w_xfer;
    logic                w_last_lane;
    logic                w_last_word;
    int                  w_llr_ext;
    logic [Q-1:0]        w_sat;
    logic [P*Q-1:0]      w_word;

    assign w_last_lane = (r_lane_cnt == LANE_W'(P - 1));
    assign w_last_word = (r_word_cnt == CNT_W'(WORDS - 1));

    // Symmetric saturation of the incoming LLR to Q-bit two's complement.
    always_comb begin
        w_llr_ext = int'($signed(in_llr));
        w_sat     = w_llr_ext[Q-1:0];
        if (CLIP) begin
            if (w_llr_ext > SAT_MAX) begin
                w_sat = Q'(SAT_MAX);
            end else if (w_llr_ext < -SAT_MAX) begin
                w_sat = Q'(-SAT_MAX);
            end
        end
    end

    // Pack register with the current LLR merged into its lane; on the last
    // lane this is the completed word that goes straight to the output register.
    always_comb begin
        w_word = r_pack;
        w_word[r_lane_cnt*Q +: Q] = w_sat;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state handshake/ownership outputs.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        channel  = 1'b0;
        w_xfer   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                w_xfer   = in_valid;
                if (in_valid && w_last_lane && w_last_word) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy   = 1'b1;
                w_next = S_DEC;
            end
            S_DEC: begin
                busy    = 1'b1;
                channel = 1'b1;
                if (frame_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Lane/word counters, pack register and the registered word output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane_cnt      <= '0;
            r_word_cnt      <= '0;
            r_pack          <= '0;
            r_w_channel     <= '0;
            r_channel_count <= '0;
            r_channel_ready <= 1'b0;
        end else begin
            r_channel_ready <= 1'b0;
            if (w_xfer) begin
                r_pack <= w_word;
                if (w_last_lane) begin
                    r_lane_cnt      <= '0;
                    r_word_cnt      <= r_word_cnt + CNT_W'(1);
                    r_w_channel     <= w_word;
                    r_channel_count <= r_word_cnt;
                    r_channel_ready <= 1'b1;
                end else begin
                    r_lane_cnt <= r_lane_cnt + LANE_W'(1);
                end
            end
            if (r_state == S_FLUSH) begin
                r_lane_cnt <= '0;
                r_word_cnt <= '0;
            end
        end
    end

    assign W_channel     = r_w_channel;
    assign channel_count = r_channel_count;
    assign channel_ready = r_channel_ready;

endmodule

// File: tb/tb_channel_loader.sv
// Scoreboard bench for channel_loader: the driver pushes expected words from a
// frame-level reference model; a negedge monitor pops and compares on strobes.
module tb_channel_loader;

    localparam int N     = 1024;
    localparam int P     = 64;
    localparam int Q     = 6;
    localparam int IN_W  = 8;
    localparam int CNT_W = 5;
    localparam int WORDS = N / P;
    localparam int SATV  = 31;

    localparam int MI = 0;
    localparam int ML = 1;
    localparam int MF = 2;
    localparam int MD = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [IN_W-1:0]    in_llr = '0;
    logic               frame_done = 1'b0;
    logic               in_ready;
    logic [P*Q-1:0]     W_channel;
    logic [CNT_W-1:0]   channel_count;
    logic               channel_ready;
    logic               channel;
    logic               busy;

    typedef struct {
        logic [P*Q-1:0] word;
        int             cnt;
        int             due;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nstrobe = 0;
    int   m_mode = MI;
    int   m_nacc = 0;
    int   m_lanes[P];

    always #5 clk = ~clk;

    channel_loader #(
        .N(N),
        .P(P),
        .Q(Q),
        .IN_W(IN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_llr(in_llr),
        .in_ready(in_ready),
        .W_channel(W_channel),
        .channel_count(channel_count),
        .channel_ready(channel_ready),
        .channel(channel),
        .frame_done(frame_done),
        .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [P*Q-1:0] act, input logic [P*Q-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int sat(input int x);
        if (x > SATV) return SATV;
        if (x < -SATV) return -SATV;
        return x;
    endfunction

    function automatic logic [7:0] pat_val(input int pat, input int idx);
        int t[5];
        t = '{127, -128, 31, -32, 5};
        case (pat)
            0: return 8'(idx % 16);
            1: return 8'($urandom_range(255));
            default: return 8'(t[idx % 5]);
        endcase
    endfunction

    task automatic push_word(input int cnt);
        exp_t e;
        e.word = '0;
        for (int k = 0; k < P; k++) e.word[k*Q +: Q] = Q'(m_lanes[k]);
        e.cnt = cnt;
        e.due = cyc + 1;
        expq.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected word, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst && channel_ready) begin
            nstrobe++;
            check("strobe_with_channel", channel, 1'b0);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_unexpected actual=count %0d required=no strobe", channel_count);
            end else begin
                e = expq.pop_front();
                check("word", W_channel, e.word);
                check("count", channel_count, e.cnt);
                check("strobe_cycle", cyc, e.due);
            end
        end
    end

    // One clock of stimulus: drive, compare status outputs, advance the model.
    task automatic step(input logic v, input logic [7:0] llr, input logic st, input logic fd);
        in_valid   = v;
        in_llr     = llr;
        start      = st;
        frame_done = fd;
        @(negedge clk);
        check("in_ready", in_ready, m_mode == ML);
        check("busy", busy, m_mode != MI);
        check("channel", channel, m_mode == MD);
        case (m_mode)
            MI: if (st) m_mode = ML;
            ML: if (v) begin
                m_lanes[m_nacc % P] = sat(int'($signed(llr)));
                m_nacc++;
                if (m_nacc % P == 0) push_word(m_nacc / P - 1);
                if (m_nacc == N) m_mode = MF;
            end
            MF: begin
                m_mode = MD;
                m_nacc = 0;
            end
            default: if (fd) m_mode = MI;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        frame_done = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_channel", channel, 1'b0);
        check("rst_channel_ready", channel_ready, 1'b0);
        check("rst_W_channel", W_channel, '0);
        check("rst_channel_count", channel_count, '0);
        expq.delete();
        m_mode = MI;
        m_nacc = 0;
        for (int k = 0; k < P; k++) m_lanes[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Start a frame and feed LLRs until stop_at are accepted or the frame ends.
    task automatic run_frame(input int pat, input int duty, input int stop_at);
        int guard;
        logic v;
        nstrobe = 0;
        step(1'b1, 8'($urandom_range(255)), 1'b1, 1'b0);
        guard = 0;
        while (m_mode == ML && m_nacc < stop_at && guard < 5000) begin
            v = ($urandom_range(99) < duty);
            step(v, pat_val(pat, m_nacc), ($urandom_range(39) == 0), ($urandom_range(39) == 0));
            guard++;
        end
        check("load_budget", guard < 5000, 1'b1);
    endtask

    task automatic end_frame(input logic with_start);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        repeat ($urandom_range(4, 1)) step(1'b1, 8'($urandom_range(255)), 1'($urandom_range(1)), 1'b0);
        check("strobes_per_frame", nstrobe, WORDS);
        check("queue_drained", expq.size(), 0);
        step(1'b0, 8'h00, with_start, 1'b1);
    endtask

    initial begin
        #2;
        do_reset();
        repeat (3) step(1'b1, 8'h11, 1'b0, 1'b0);

        run_frame(0, 100, N);
        end_frame(1'b0);

        run_frame(0, 40, N);
        end_frame(1'b1);
        repeat (2) step(1'b1, 8'h22, 1'b0, 1'b0);

        run_frame(2, 100, N);
        end_frame(1'b0);
        run_frame(1, 60, N);
        end_frame(1'b0);

        run_frame(0, 100, 300);
        check("partial_count", m_nacc, 300);
        do_reset();
        run_frame(1, 70, N);
        end_frame(1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
